// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU sharing arbiter.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W_DEF  = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational round-robin grant.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // On a tie the requester that was not served last wins.
  assign gnt0_o = valid0_i & (~valid1_i | last_grant_i);
  assign gnt1_o = valid1_i & (~valid0_i | ~last_grant_i);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one external ALU between two requesters
// with round-robin arbitration, registered operands and registered result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_c
);

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OP_W-1:0]  alu_op_q;
  logic [WIDTH-1:0] result_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;

  logic gnt0, gnt1;
  logic rsp_hs;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  assign req0_ready = (state_q == S_IDLE) & gnt0;
  assign req1_ready = (state_q == S_IDLE) & gnt1;

  assign rsp_hs = owner_q ? (rsp1_valid_q & rsp1_ready) : (rsp0_valid_q & rsp0_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_valid && req0_ready) begin
            alu_a_q  <= req0_a;
            alu_b_q  <= req0_b;
            alu_op_q <= req0_op;
            owner_q  <= 1'b0;
            state_q  <= S_EXEC;
          end else if (req1_valid && req1_ready) begin
            alu_a_q  <= req1_a;
            alu_b_q  <= req1_b;
            alu_op_q <= req1_op;
            owner_q  <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Operands have been stable at the ALU for a full cycle here.
          result_q     <= alu_c;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_c     = result_q;
  assign rsp1_c     = result_q;

endmodule
